// File: rtl/camera_capture_pkg.sv
// Shared types and constants for the camera frame capture block.
package camera_capture_pkg;

    typedef enum logic [1:0] {
        S_WAIT_VSYNC = 2'd0,
        S_VSYNC      = 2'd1,
        S_ACTIVE     = 2'd2
    } capture_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int VGA_ACTIVE_COLUMNS = 640;
    localparam int VGA_ACTIVE_ROWS    = 480;

    // The camera sends the high byte first; it lands in [15:8] of the pixel.
    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/rgb565_byte_packer.sv
// Pairs consecutive camera bytes into one RGB565 pixel.
// pixel_o/strobe_o are combinational so the top can register them together
// with the pixel coordinates in the same cycle.
module rgb565_byte_packer
    import camera_capture_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        accept_i,
    input  logic        flush_i,
    input  logic [7:0]  byte_i,
    output logic        phase_o,
    output logic [15:0] pixel_o,
    output logic        strobe_o
);

    logic       phase_q;
    logic [7:0] high_q;

    // Toggle the byte phase on each accepted byte; hold the first byte of a pair.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q <= 1'b0;
            high_q  <= 8'h00;
        end else if (flush_i) begin
            phase_q <= 1'b0;
        end else if (accept_i) begin
            if (!phase_q) begin
                high_q <= byte_i;
            end
            phase_q <= ~phase_q;
        end
    end

    assign phase_o  = phase_q;
    assign pixel_o  = pack_rgb565(high_q, byte_i);
    assign strobe_o = accept_i & phase_q;

endmodule

// File: rtl/camera_frame_capture.sv
// Camera sync-pulse receiver: VSYNC/HREF/byte stream -> RGB565 pixels with
// x/y and frame-buffer write address.
// Build option: define DOWNSAMPLE_EN to keep only even-x/even-y pixels.
// Output handshake: pixel_valid_o is a one-cycle strobe with no backpressure;
// pixel_o, addr_o, x_o and y_o are meaningful only in a cycle where it is high.
// state_o exposes the capture FSM state for debug.
module camera_frame_capture
    import camera_capture_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = VGA_ACTIVE_COLUMNS,
    parameter int ACTIVE_ROWS    = VGA_ACTIVE_ROWS,
`ifdef DOWNSAMPLE_EN
    parameter int FRAME_PIXELS   = (VGA_ACTIVE_COLUMNS / 2) * (VGA_ACTIVE_ROWS / 2)
`else
    parameter int FRAME_PIXELS   = VGA_ACTIVE_COLUMNS * VGA_ACTIVE_ROWS
`endif
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              enable_i,
    input  logic                              vsync_i,
    input  logic                              href_i,
    input  logic [7:0]                        data_i,
    output logic [15:0]                       pixel_o,
    output logic                              pixel_valid_o,
    output logic [$clog2(FRAME_PIXELS)-1:0]   addr_o,
    output logic [$clog2(ACTIVE_COLUMNS)-1:0] x_o,
    output logic [$clog2(ACTIVE_ROWS)-1:0]    y_o,
    output logic                              frame_done_o,
    output logic                              frame_err_o,
    output logic [1:0]                        state_o
);

    localparam int AW  = $clog2(FRAME_PIXELS);
    localparam int XOW = $clog2(ACTIVE_COLUMNS);
    localparam int YOW = $clog2(ACTIVE_ROWS);
    // Internal counters are one value wider so they can saturate at the limit.
    localparam int XW  = $clog2(ACTIVE_COLUMNS + 1);
    localparam int YW  = $clog2(ACTIVE_ROWS + 1);
    localparam int CW  = $clog2(FRAME_PIXELS + 1);
    localparam logic [XW-1:0] COLS_L = XW'(ACTIVE_COLUMNS);
    localparam logic [YW-1:0] ROWS_L = YW'(ACTIVE_ROWS);
    localparam logic [CW-1:0] FP_L   = CW'(FRAME_PIXELS);

    capture_state_t state_q, state_d;
    logic           enter_active, done_evt;

    logic       vsync_q, vsync_d, href_q, href_d;
    logic [7:0] data_q;
    logic       vsync_rise, vsync_fall, href_fall;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [CW-1:0] addr_cnt;

    logic        active, accept, flush, line_end;
    logic        packer_phase, pix_done;
    logic [15:0] packer_pixel;
    logic        x_in, y_in, addr_ok, keep, emit, err_evt;

    // Register camera pins once, plus a delayed copy for edge detection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vsync_q <= 1'b0;
            vsync_d <= 1'b0;
            href_q  <= 1'b0;
            href_d  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            vsync_q <= vsync_i;
            vsync_d <= vsync_q;
            href_q  <= href_i;
            href_d  <= href_q;
            data_q  <= data_i;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_d;
    assign vsync_fall = ~vsync_q & vsync_d;
    assign href_fall  = ~href_q & href_d;

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_WAIT_VSYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a full vsync pulse must be seen before capture starts.
    always_comb begin
        state_d      = state_q;
        enter_active = 1'b0;
        done_evt     = 1'b0;
        case (state_q)
            S_WAIT_VSYNC: if (vsync_rise) state_d = S_VSYNC;
            S_VSYNC: begin
                if (vsync_fall) begin
                    if (enable_i) begin
                        state_d      = S_ACTIVE;
                        enter_active = 1'b1;
                    end else begin
                        state_d = S_WAIT_VSYNC;
                    end
                end
            end
            S_ACTIVE: begin
                if (vsync_rise) begin
                    state_d  = S_VSYNC;
                    done_evt = 1'b1;
                end
            end
            default: state_d = S_WAIT_VSYNC;
        endcase
    end

    assign state_o  = state_q;
    assign active   = (state_q == S_ACTIVE);
    // Bytes arriving with vsync already high belong to an aborted line.
    assign accept   = active & href_q & ~vsync_q;
    assign flush    = ~active | href_fall;
    assign line_end = active & href_fall;

    rgb565_byte_packer u_packer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .accept_i (accept),
        .flush_i  (flush),
        .byte_i   (data_q),
        .phase_o  (packer_phase),
        .pixel_o  (packer_pixel),
        .strobe_o (pix_done)
    );

    assign x_in    = (x_cnt < COLS_L);
    assign y_in    = (y_cnt < ROWS_L);
    assign addr_ok = (addr_cnt < FP_L);
`ifdef DOWNSAMPLE_EN
    assign keep    = ~x_cnt[0] & ~y_cnt[0];
`else
    assign keep    = 1'b1;
`endif
    assign emit    = pix_done & x_in & y_in & keep & addr_ok;

    // Frame-format violations that set the sticky error flag.
    always_comb begin
        err_evt = 1'b0;
        if (pix_done && !(x_in && y_in)) err_evt = 1'b1;
        if (pix_done && x_in && y_in && keep && !addr_ok) err_evt = 1'b1;
        if (line_end && (packer_phase || (x_cnt != COLS_L))) err_evt = 1'b1;
        if (done_evt && (href_q || (y_cnt != ROWS_L))) err_evt = 1'b1;
    end

    // Counters, pixel outputs and status flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_cnt         <= '0;
            y_cnt         <= '0;
            addr_cnt      <= '0;
            pixel_o       <= 16'h0000;
            pixel_valid_o <= 1'b0;
            addr_o        <= '0;
            x_o           <= '0;
            y_o           <= '0;
            frame_done_o  <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            pixel_valid_o <= 1'b0;
            frame_done_o  <= done_evt;
            if (enter_active) begin
                x_cnt       <= '0;
                y_cnt       <= '0;
                addr_cnt    <= '0;
                addr_o      <= '0;
                x_o         <= '0;
                y_o         <= '0;
                frame_err_o <= 1'b0;
            end else begin
                if (err_evt) frame_err_o <= 1'b1;
                if (pix_done && x_in) x_cnt <= x_cnt + XW'(1);
                if (emit) begin
                    pixel_o       <= packer_pixel;
                    pixel_valid_o <= 1'b1;
                    addr_o        <= addr_cnt[AW-1:0];
                    x_o           <= x_cnt[XOW-1:0];
                    y_o           <= y_cnt[YOW-1:0];
                    addr_cnt      <= addr_cnt + CW'(1);
                end
                if (line_end) begin
                    x_cnt <= '0;
                    if (y_in) y_cnt <= y_cnt + YW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_frame_capture.sv
// Bench for camera_frame_capture on a reduced 8x4 frame.
module tb_camera_frame_capture;

    localparam int COLS = 8;
    localparam int ROWS = 4;
`ifdef DOWNSAMPLE_EN
    localparam int FP = 8;
    localparam bit DS = 1'b1;
`else
    localparam int FP = 32;
    localparam bit DS = 1'b0;
`endif
    localparam int AW  = $clog2(FP);
    localparam int XOW = $clog2(COLS);
    localparam int YOW = $clog2(ROWS);
    localparam int IW  = 32 + 16 + AW + XOW + YOW;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    logic enable_i = 1'b0;
    logic vsync_i = 1'b0;
    logic href_i = 1'b0;
    logic [7:0] data_i = 8'h00;

    logic [15:0]    pixel_o;
    logic           pixel_valid_o;
    logic [AW-1:0]  addr_o;
    logic [XOW-1:0] x_o;
    logic [YOW-1:0] y_o;
    logic           frame_done_o;
    logic           frame_err_o;
    logic [1:0]     state_o;

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    camera_frame_capture #(
        .ACTIVE_COLUMNS (COLS),
        .ACTIVE_ROWS    (ROWS),
        .FRAME_PIXELS   (FP)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .vsync_i       (vsync_i),
        .href_i        (href_i),
        .data_i        (data_i),
        .pixel_o       (pixel_o),
        .pixel_valid_o (pixel_valid_o),
        .addr_o        (addr_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .frame_done_o  (frame_done_o),
        .frame_err_o   (frame_err_o),
        .state_o       (state_o)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] act_item, exp_item;
    int exp_done = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    // Expected-behaviour model state.
    bit        m_active = 1'b0;
    bit        m_err = 1'b0;
    int        m_x = 0, m_y = 0, m_addr = 0, m_bytes = 0;
    logic [7:0] m_hi = 8'h00;
    int        line_no = 0;

    // Monitor: every strobe pops one expected {cycle, pixel, addr, x, y}.
    always @(negedge clk_i) begin
        if (pixel_valid_o) begin
            checks++;
            act_item = {32'(cyc), pixel_o, addr_o, x_o, y_o};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: got {cyc,pix,addr,x,y}=%h, required no strobe", act_item);
            end else begin
                exp_item = exp_q.pop_front();
                if (act_item !== exp_item) begin
                    errors++;
                    $display("FAIL pixel_scoreboard: got {cyc,pix,addr,x,y}=%h required %h", act_item, exp_item);
                end
            end
        end
        if (frame_done_o) begin
            done_cnt++;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL frame_done_width: got high 2 cycles, required 1-cycle pulse");
            end
        end
        prev_done = frame_done_o;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic complete_pixel(input logic [15:0] pix);
        if (m_x < COLS && m_y < ROWS) begin
            if (!DS || ((m_x % 2) == 0 && (m_y % 2) == 0)) begin
                if (m_addr < FP) begin
                    exp_q.push_back({32'(cyc + 2), pix, AW'(m_addr), XOW'(m_x), YOW'(m_y)});
                    m_addr++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            m_err = 1'b1;
        end
        if (m_x < COLS) m_x++;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        href_i = 1'b1;
        data_i = b;
        if (m_active) begin
            if (m_bytes % 2 == 0) m_hi = b;
            else complete_pixel({m_hi, b});
        end
        m_bytes++;
        tick();
    endtask

    task automatic end_line();
        href_i = 1'b0;
        if (m_active) begin
            if ((m_bytes % 2) != 0 || m_x != COLS) m_err = 1'b1;
            m_x = 0;
            if (m_y < ROWS) m_y++;
        end
        m_bytes = 0;
        repeat (4) tick();
    endtask

    task automatic send_line(input int nbytes, input bit first);
        logic [7:0] b;
        for (int k = 0; k < nbytes; k++) begin
            b = 8'((line_no * 29 + k * 11 + 3) & 255);
            if (first && k == 0) b = 8'hF8;
            if (first && k == 1) b = 8'h00;
            drive_byte(b);
        end
        line_no++;
        end_line();
    endtask

    // Vsync pulse: closes the current frame and samples enable at its fall.
    task automatic vsync_pulse(input bit en, input bit keep_href);
        enable_i = en;
        vsync_i  = 1'b1;
        if (m_active) begin
            exp_done++;
            if (keep_href || m_y != ROWS) m_err = 1'b1;
        end
        m_active = 1'b0;
        if (keep_href) begin
            href_i = 1'b1;
            data_i = 8'h55;
            tick();
            href_i = 1'b0;
        end
        repeat (4) tick();
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("err_during_vsync", 32'(frame_err_o), 32'(m_err));
        vsync_i = 1'b0;
        if (en) begin
            m_active = 1'b1;
            m_x = 0;
            m_y = 0;
            m_addr = 0;
            m_err = 1'b0;
        end
        m_bytes = 0;
        repeat (5) tick();
        check("err_after_vsync", 32'(frame_err_o), 32'(m_err));
        check("state_after_vsync", 32'(state_o), en ? 32'd2 : 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 reset_i = 1'b1;
        repeat (3) tick();
        check("rst_pixel_valid", 32'(pixel_valid_o), 0);
        check("rst_frame_done", 32'(frame_done_o), 0);
        check("rst_frame_err", 32'(frame_err_o), 0);
        check("rst_addr", 32'(addr_o), 0);
        check("rst_x", 32'(x_o), 0);
        check("rst_y", 32'(y_o), 0);
        check("rst_pixel", 32'(pixel_o), 0);
        check("rst_state", 32'(state_o), 0);
        reset_i = 1'b0;
        tick();

        // Partial frame with a reset in the middle of a line: discarded.
        enable_i = 1'b1;
        send_line(16, 1'b0);
        send_line(16, 1'b0);
        for (int k = 0; k < 5; k++) drive_byte(8'(k + 1));
        reset_i = 1'b1;
        m_active = 1'b0;
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) drive_byte(8'(k + 9));
        end_line();
        check("state_after_midreset", 32'(state_o), 0);

        // Frame 1: full frame, first pixel bytes F8,00.
        vsync_pulse(1'b1, 1'b0);
        send_line(16, 1'b1);
        for (int l = 0; l < ROWS - 1; l++) send_line(16, 1'b0);

        // Frame 2: first line one byte short.
        vsync_pulse(1'b1, 1'b0);
        send_line(2 * COLS - 1, 1'b0);
        for (int l = 0; l < ROWS - 1; l++) send_line(16, 1'b0);

        // Frame 3: normal; closing pulse has enable low.
        vsync_pulse(1'b1, 1'b0);
        for (int l = 0; l < ROWS; l++) send_line(16, 1'b0);
        vsync_pulse(1'b0, 1'b0);

        // Disabled frame: nothing captured.
        for (int l = 0; l < ROWS; l++) send_line(16, 1'b0);

        // Frame 5: two extra lines.
        vsync_pulse(1'b1, 1'b0);
        for (int l = 0; l < ROWS + 2; l++) send_line(16, 1'b0);
        check("addr_saturated", 32'(addr_o), 32'(FP - 1));
        check("err_extra_lines", 32'(frame_err_o), 1);

        // Frame 6: vsync rises in the middle of a line.
        vsync_pulse(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive_byte(8'(8'h40 + k));
        vsync_pulse(1'b1, 1'b1);

        // Frame 7: normal, must restart at address 0.
        for (int l = 0; l < ROWS; l++) send_line(16, 1'b0);
        vsync_pulse(1'b0, 1'b0);

        repeat (6) tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        check("done_total", 32'(done_cnt), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish, required finish within 40000 cycles");
        $fatal(1, "timeout");
    end

endmodule
